// File: rtl/load_store_unit.sv
// Load/store unit: runs one load or store per start over a req/ack data-memory port.
// Latency: a faulting access completes one cycle after start; otherwise done follows mem_ack by one cycle.
// Backpressure: mem_req is held until mem_ack or the wait-cycle abort; start is ignored whenever busy.
// Ports: clk/reset (sync, active-high); start/is_store/funct3/addr/store_data request from control FSM;
//        busy/done/misaligned/illegal/timeout status; load_data extended load result;
//        mem_req/mem_we/mem_addr/mem_wdata/mem_be/mem_ack/mem_rdata data-memory port.
module load_store_unit #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned,
  output logic            illegal,
  output logic            timeout,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_be,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic             we_q, unsigned_q;
  logic [1:0]       size_q, lo_q;
  logic [XLEN-1:0]  addr_q, wdata_q, load_q;
  logic [3:0]       be_q;
  logic             mis_q, ill_q, to_q;

  // Request decode, evaluated on the raw inputs so it can be latched with start
  logic [1:0]      size_in;
  logic            legal_in, mis_in;
  logic [3:0]      be_in;
  logic [XLEN-1:0] wdata_in;

  always_comb begin
    size_in = funct3[1:0];
    if (is_store) legal_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          legal_in = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                             (funct3 == 3'b100) || (funct3 == 3'b101);
    // Alignment is only meaningful for a legal encoding; illegal ops report illegal alone
    mis_in = legal_in && (((size_in == 2'b01) && addr[0]) ||
                          ((size_in == 2'b10) && (addr[1:0] != 2'b00)));
    case (size_in)
      2'b00: begin
        be_in    = 4'b0001 << addr[1:0];
        wdata_in = XLEN'({4{store_data[7:0]}});
      end
      2'b01: begin
        be_in    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = XLEN'({2{store_data[15:0]}});
      end
      default: begin
        be_in    = 4'b1111;
        wdata_in = store_data;
      end
    endcase
  end

  // Load alignment and extension from the latched access shape
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] load_ext;

  always_comb begin
    rd_byte = mem_rdata[{lo_q, 3'b000} +: 8];
    rd_half = mem_rdata[{lo_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   load_ext = {{(XLEN-8){~unsigned_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{(XLEN-16){~unsigned_q & rd_half[15]}}, rd_half};
      default: load_ext = mem_rdata;
    endcase
  end

  logic timeout_hit;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (!legal_in || mis_in) ? RESP : WAIT;
      // Ack is tested first so an ack on the threshold cycle completes normally
      WAIT: if (mem_ack || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      load_q     <= '0;
      mis_q      <= 1'b0;
      ill_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          we_q       <= is_store;
          unsigned_q <= funct3[2];
          size_q     <= size_in;
          lo_q       <= addr[1:0];
          addr_q     <= {addr[XLEN-1:2], 2'b00};
          wdata_q    <= wdata_in;
          be_q       <= be_in;
          ill_q      <= !legal_in;
          mis_q      <= mis_in;
          to_q       <= 1'b0;
          cnt        <= '0;
        end
        WAIT: begin
          if (mem_ack) begin
            // Stores leave the previous load result in place
            if (!we_q) load_q <= load_ext;
          end else if (timeout_hit) begin
            to_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state != IDLE);
  assign done       = (state == RESP);
  assign misaligned = done & mis_q;
  assign illegal    = done & ill_q;
  assign timeout    = done & to_q;
  assign mem_req    = (state == WAIT);
  assign mem_we     = mem_req & we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign load_data  = load_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU in the multi-cycle core.
- Takes the ALU-computed effective address and the rs2 value, and runs one load or store over a variable-latency req/ack data-memory port.
- Aligns and sign/zero-extends load data and returns it to the ResultData writeback mux.
- Handshakes with the control FSM through start/busy/done and reports misaligned, illegal and timed-out accesses.

Parameters:
XLEN, 32, data and address width
TIMEOUT_CYCLES, 255, max cycles in WAIT without mem_ack before abort (1..2^CNT_W-1)
CNT_W, 8, width of the wait-cycle counter

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request from control FSM; sampled only in IDLE
is_store  in  1  1 = store, 0 = load; sampled with start
funct3  in  3  instr[14:12]; sampled with start
addr  in  XLEN  effective address from ALU; sampled with start
store_data  in  XLEN  rs2 value; sampled with start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
load_data  out  XLEN  extended load result
misaligned  out  1  valid with done
illegal  out  1  valid with done
timeout  out  1  valid with done
mem_req  out  1  memory request, held until ack or abort
mem_we  out  1  write enable, valid while mem_req
mem_addr  out  XLEN  word address: {addr[XLEN-1:2],2'b00}
mem_wdata  out  XLEN  lane-replicated store data
mem_be  out  4  byte enables
mem_ack  in  1  memory completion; rdata valid same cycle
mem_rdata  in  XLEN  read word

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. A reset during WAIT drops mem_req on the next edge with no done; a pending ack is discarded.
- Encodings:
  - Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Stores: SB 000, SH 001, SW 010.
  - Any other funct3 is illegal.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=00.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On start, latch the inputs.
  - If illegal or misaligned: go to RESP with the corresponding flag set; no mem_req ever issued.
  - Otherwise: go to WAIT, counter=0.
- WAIT:
  - mem_req=1; mem_we/mem_addr/mem_wdata/mem_be held constant.
  - On mem_ack: capture the load result, go to RESP.
  - Otherwise counter++; when counter reaches TIMEOUT_CYCLES with no ack, go to RESP with timeout=1.
- RESP: done=1 for exactly one cycle with the flags; next state is IDLE. Flags return to 0 in IDLE.
- Latency:
  - Fault: start at cycle N gives done at N+1.
  - Normal: start at N, mem_req first high at N+1; mem_ack at cycle K gives done at K+1. Minimum is 2 cycles.
- Byte enables and write data:
  - Byte: be=4'b0001<<addr[1:0]; wdata = store_data[7:0] replicated ×4.
  - Half: be=addr[1]?1100:0011; wdata = store_data[15:0] replicated ×2.
  - Word: be=1111; wdata = store_data.
  - Loads drive the same be with mem_we=0.
- Load extension: select byte at rdata[8*addr[1:0]+:8] or half at rdata[16*addr[1]+:16]; sign-extend (LB/LH) or zero-extend (LBU/LHU).
- load_data updates only on an acked load. It holds across stores, faults and timeouts until the next successful load.
- Corner cases:
  - start while busy: ignored, no queueing.
  - mem_ack outside WAIT: ignored.
  - start in the RESP cycle: ignored; the FSM must re-issue from IDLE.
  - mem_ack and timeout threshold in the same cycle: ack wins, timeout=0.

Test Plan:
- LB addr=0x1003, rdata=0x80FF_1234, ack 1 cycle after req → done with load_data=0xFFFF_FF80, mem_addr=0x1000, be=1000, mem_we=0.
- LHU addr=0x2002, rdata=0xBEEF_0001 → load_data=0x0000_BEEF. Then LH with the same data → 0xFFFF_BEEF.
- SB addr=0x3001, store_data=0x1234_56AB, ack after 5 cycles → mem_wdata=0xABAB_ABAB, be=0010, mem_req high exactly 5 cycles, done one cycle after ack, load_data unchanged.
- LW addr=0x4002 → done at start+1 with misaligned=1 and mem_req never asserted. funct3=011 → illegal=1.
- TIMEOUT_CYCLES=4, no ack → mem_req high 5 cycles, then done with timeout=1, mem_req=0. Then a late ack is ignored.
- Reset asserted mid-WAIT → next cycle mem_req=0, busy=0, done=0. A start during busy is ignored (single done observed).
